// File: rtl/coproc0_irq.sv
// coproc0_irq: system coprocessor with MFC0/MTC0/RFE pipeline, external interrupts and
// exception entry.
//   clk, rst                 clock, asynchronous active-high reset
//   i_*_stall                CU stalls; pipeline and architectural updates freeze while any is set
//   i_instr                  fetched instruction, registered into p1
//   i_cop0_alu_result_p2     MTC0 data, captured at p2
//   i_irq                    asynchronous level interrupt lines
//   i_exc_req/code/pc        synchronous exception request, code and PC to save
//   o_decode_error, o_cop0_* p1 decode results and MFC0 read value
//   o_irq_pending            an interrupt will be taken at the next non-stalled edge
//   o_redirect, o_redirect_pc  one-cycle flush-and-jump to the latched vector
// Optional: define COP0_CYCLE_COUNT_EN to add the free-running COUNT register at 0x09.

`ifndef CPU_PROCID_CODE
`define CPU_PROCID_CODE 32'h0000_0301
`endif

module coproc0_irq #(
  parameter int unsigned NIRQ        = 4,
  parameter int unsigned VEC_SHIFT   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_exec_stall,
  input  logic            i_mem_stall,
  input  logic            i_fetch_stall,
  input  logic [31:0]     i_instr,
  input  logic [31:0]     i_cop0_alu_result_p2,
  input  logic [NIRQ-1:0] i_irq,
  input  logic            i_exc_req,
  input  logic [3:0]      i_exc_code,
  input  logic [31:0]     i_exc_pc,
  output logic            o_decode_error,
  output logic            o_cop0_op_p1,
  output logic [4:0]      o_cop0_cop_p1,
  output logic [4:0]      o_cop0_reg_no_p1,
  output logic [4:0]      o_cop0_rt_no_p1,
  output logic [31:0]     o_cop0_reg_val_p1,
  output logic            o_irq_pending,
  output logic            o_redirect,
  output logic [31:0]     o_redirect_pc
);

  localparam logic [5:0] OpCop0  = 6'b010000;
  localparam logic [4:0] SubMf   = 5'b00000;
  localparam logic [4:0] SubMt   = 5'b00100;
  localparam logic [4:0] SubCo   = 5'b10000;
  localparam logic [5:0] FuncRfe = 6'b010000;
`ifdef COP0_CYCLE_COUNT_EN
  localparam logic [4:0] RegCount = 5'h09;
`endif
  localparam logic [4:0] RegIvt   = 5'h0A;
  localparam logic [4:0] RegPsr   = 5'h0B;
  localparam logic [4:0] RegSr    = 5'h0C;
  localparam logic [4:0] RegCause = 5'h0D;
  localparam logic [4:0] RegEpc   = 5'h0E;
  localparam logic [4:0] RegPrid  = 5'h0F;

  typedef enum logic {StIdle, StEntry} state_t;

  logic w_core_stall;
  assign w_core_stall = i_exec_stall | i_mem_stall | i_fetch_stall;

  // ---------------- p1 decode ----------------
  logic [31:0] r_instr;
  logic [5:0]  w_opcode, w_func;
  logic [4:0]  w_sub, w_rt, w_rd, w_rsvd;
  logic        w_is_cop0, w_is_mf, w_is_mt, w_is_rfe, w_err;

  assign {w_opcode, w_sub, w_rt, w_rd, w_rsvd, w_func} = r_instr;

  always_comb begin
    w_is_cop0 = (w_opcode == OpCop0);
    w_is_mf   = 1'b0;
    w_is_mt   = 1'b0;
    w_is_rfe  = 1'b0;
    w_err     = 1'b0;
    if (w_is_cop0) begin
      case (w_sub)
        SubMf: if (w_rsvd == 5'd0 && w_func == 6'd0) w_is_mf = 1'b1; else w_err = 1'b1;
        SubMt: if (w_rsvd == 5'd0 && w_func == 6'd0) w_is_mt = 1'b1; else w_err = 1'b1;
        SubCo: begin
          if (w_func == FuncRfe && w_rt == 5'd0 && w_rd == 5'd0 && w_rsvd == 5'd0)
            w_is_rfe = 1'b1;
          else
            w_err = 1'b1;
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  // ---------------- p2 / p3 pipeline ----------------
  logic        r_p2_mt, r_p2_rfe, r_p3_mt, r_p3_rfe;
  logic [4:0]  r_p2_rd, r_p3_rd;
  logic [31:0] r_p3_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr   <= '0;
      r_p2_mt   <= 1'b0;
      r_p2_rfe  <= 1'b0;
      r_p2_rd   <= '0;
      r_p3_mt   <= 1'b0;
      r_p3_rfe  <= 1'b0;
      r_p3_rd   <= '0;
      r_p3_data <= '0;
    end else if (!w_core_stall) begin
      r_instr   <= i_instr;
      r_p2_mt   <= w_is_mt;
      r_p2_rfe  <= w_is_rfe;
      r_p2_rd   <= w_rd;
      r_p3_mt   <= r_p2_mt;
      r_p3_rfe  <= r_p2_rfe;
      r_p3_rd   <= r_p2_rd;
      r_p3_data <= i_cop0_alu_result_p2;
    end
  end

  logic w_wb_mt, w_wb_rfe;
  assign w_wb_mt  = r_p3_mt & ~w_core_stall;
  assign w_wb_rfe = r_p3_rfe & ~w_core_stall;

  // ---------------- interrupt synchronisers ----------------
  logic [NIRQ-1:0] r_sync [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_irq;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // ---------------- architectural registers ----------------
  logic [21:0]     r_ivt;
  logic            r_psr_ie, r_sr_ie;
  logic [NIRQ-1:0] r_sr_im;
  logic [31:0]     r_epc, r_vec;
  logic [3:0]      r_cause_code;
  state_t          r_state, w_state_next;

  logic [NIRQ-1:0] w_ip;
  logic            w_irq_pending, w_take;
  logic [3:0]      w_code;
  logic [31:0]     w_vec;

  assign w_ip          = r_sync[SYNC_STAGES-1] & r_sr_im;
  assign w_irq_pending = r_sr_ie & (|w_ip) & (r_state == StIdle);
  assign w_take        = (r_state == StIdle) & ~w_core_stall & (i_exc_req | w_irq_pending);
  // Exceptions outrank interrupts; interrupts always use code 0.
  assign w_code        = i_exc_req ? i_exc_code : 4'd0;
  assign w_vec         = {r_ivt, 10'b0} + ({28'b0, w_code} << VEC_SHIFT);

  // Later assignments win: entry overrides MT/RFE for EPC, PSR, SR.IE and CAUSE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ivt        <= '0;
      r_psr_ie     <= 1'b0;
      r_sr_ie      <= 1'b0;
      r_sr_im      <= '0;
      r_epc        <= '0;
      r_cause_code <= '0;
      r_vec        <= '0;
    end else begin
      if (w_wb_mt) begin
        case (r_p3_rd)
          RegIvt: r_ivt    <= r_p3_data[31:10];
          RegPsr: r_psr_ie <= r_p3_data[0];
          RegSr: begin
            r_sr_ie <= r_p3_data[0];
            r_sr_im <= r_p3_data[8 +: NIRQ];
          end
          RegEpc: r_epc    <= r_p3_data;
          default: ;
        endcase
      end
      if (w_wb_rfe) begin
        r_sr_ie  <= r_psr_ie;
        r_psr_ie <= 1'b0;
      end
      if (w_take) begin
        r_epc        <= i_exc_pc;
        r_psr_ie     <= r_sr_ie;
        r_sr_ie      <= 1'b0;
        r_cause_code <= w_code;
        r_vec        <= w_vec;
      end
    end
  end

`ifdef COP0_CYCLE_COUNT_EN
  logic [31:0] r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_wb_mt && r_p3_rd == RegCount) begin
      r_count <= r_p3_data;
    end else begin
      r_count <= r_count + 32'd1;
    end
  end
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_take) w_state_next = StEntry;
      StEntry: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_redirect    = (r_state == StEntry);
    o_redirect_pc = o_redirect ? r_vec : 32'd0;
  end

  // ---------------- read mux and p1 outputs ----------------
  logic [31:0] w_rd_val;

  always_comb begin
    w_rd_val = '0;
    case (w_rd)
`ifdef COP0_CYCLE_COUNT_EN
      RegCount: w_rd_val = r_count;
`endif
      RegIvt:   w_rd_val = {r_ivt, 10'b0};
      RegPsr:   w_rd_val[0] = r_psr_ie;
      RegSr: begin
        w_rd_val[0]         = r_sr_ie;
        w_rd_val[8 +: NIRQ] = r_sr_im;
      end
      RegCause: begin
        w_rd_val[8 +: NIRQ] = w_ip;
        w_rd_val[5:2]       = r_cause_code;
      end
      RegEpc:   w_rd_val = r_epc;
      RegPrid:  w_rd_val = `CPU_PROCID_CODE;
      default:  w_rd_val = '0;
    endcase
  end

  assign o_decode_error    = w_err;
  assign o_cop0_op_p1      = w_is_cop0;
  assign o_cop0_cop_p1     = (w_is_cop0 && (w_sub == SubMf || w_sub == SubMt)) ? w_sub : 5'd0;
  assign o_cop0_reg_no_p1  = w_rd;
  assign o_cop0_rt_no_p1   = w_rt;
  assign o_cop0_reg_val_p1 = w_is_mf ? w_rd_val : 32'd0;
  assign o_irq_pending     = w_irq_pending;

endmodule

// File: tb/tb_coproc0_irq.sv
`ifndef CPU_PROCID_CODE
`define CPU_PROCID_CODE 32'h0000_0301
`endif

module tb_coproc0_irq;
  localparam int NIRQ = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_exec_stall, i_mem_stall, i_fetch_stall;
  logic [31:0]     i_instr, i_cop0_alu_result_p2, i_exc_pc;
  logic [NIRQ-1:0] i_irq;
  logic            i_exc_req;
  logic [3:0]      i_exc_code;
  logic            o_decode_error, o_cop0_op_p1, o_irq_pending, o_redirect;
  logic [4:0]      o_cop0_cop_p1, o_cop0_reg_no_p1, o_cop0_rt_no_p1;
  logic [31:0]     o_cop0_reg_val_p1, o_redirect_pc;

  coproc0_irq #(.NIRQ(NIRQ), .VEC_SHIFT(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .i_exec_stall(i_exec_stall), .i_mem_stall(i_mem_stall), .i_fetch_stall(i_fetch_stall),
    .i_instr(i_instr), .i_cop0_alu_result_p2(i_cop0_alu_result_p2), .i_irq(i_irq),
    .i_exc_req(i_exc_req), .i_exc_code(i_exc_code), .i_exc_pc(i_exc_pc),
    .o_decode_error(o_decode_error), .o_cop0_op_p1(o_cop0_op_p1),
    .o_cop0_cop_p1(o_cop0_cop_p1), .o_cop0_reg_no_p1(o_cop0_reg_no_p1),
    .o_cop0_rt_no_p1(o_cop0_rt_no_p1), .o_cop0_reg_val_p1(o_cop0_reg_val_p1),
    .o_irq_pending(o_irq_pending), .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] instr;
    logic        op;
    logic        err;
    logic [4:0]  cop;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [31:0] val;
  } dvec_t;

  dvec_t tbl[10];

  // Reference model of the architectural registers (full 32-bit read images).
  logic [31:0] m_ivt, m_psr, m_sr, m_epc, m_cause;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] sub, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] rsvd,
                                     input logic [5:0] func);
    return {6'b010000, sub, rt, rd, rsvd, func};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] rd, input logic [31:0] data);
    i_instr = mk(5'h04, 5'($urandom_range(0, 31)), rd, 5'd0, 6'd0);
    tick();
    i_instr = 32'd0;
    tick();
    i_cop0_alu_result_p2 = data;
    tick();
    i_cop0_alu_result_p2 = 32'd0;
    tick();
  endtask

  task automatic mfc0(input logic [4:0] rd, output logic [31:0] val);
    i_instr = mk(5'h00, 5'($urandom_range(0, 31)), rd, 5'd0, 6'd0);
    tick();
    val = o_cop0_reg_val_p1;
    i_instr = 32'd0;
  endtask

  task automatic rfe();
    i_instr = mk(5'h10, 5'd0, 5'd0, 5'd0, 6'h10);
    tick();
    i_instr = 32'd0;
    tick();
    tick();
    tick();
  endtask

  task automatic expect_reg(input string name, input logic [4:0] rd, input logic [31:0] exp);
    logic [31:0] v;
    mfc0(rd, v);
    check(name, v, exp);
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] rd);
    case (rd)
      5'h0A: return m_ivt;
      5'h0B: return m_psr;
      5'h0C: return m_sr;
      5'h0D: return m_cause;
      5'h0E: return m_epc;
      5'h0F: return `CPU_PROCID_CODE;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [4:0] pick_reg();
    logic [4:0] r;
    r = 5'($urandom_range(8, 15));
`ifdef COP0_CYCLE_COUNT_EN
    if (r == 5'h09) r = 5'h0A;
`endif
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v, d, pc;
    logic [4:0]  rd;
    logic [3:0]  code;

    tbl[0] = '{32'd0,                            1'b0, 1'b0, 5'h00, 5'h00, 5'h00, 32'd0};
    tbl[1] = '{mk(5'h00, 5'd3, 5'h0F, 0, 0),     1'b1, 1'b0, 5'h00, 5'h0F, 5'h03, `CPU_PROCID_CODE};
    tbl[2] = '{mk(5'h00, 5'd1, 5'h0C, 0, 0),     1'b1, 1'b0, 5'h00, 5'h0C, 5'h01, 32'd0};
    tbl[3] = '{mk(5'h04, 5'd7, 5'h0E, 0, 0),     1'b1, 1'b0, 5'h04, 5'h0E, 5'h07, 32'd0};
    tbl[4] = '{mk(5'h00, 5'd2, 5'h0F, 0, 6'h01), 1'b1, 1'b1, 5'h00, 5'h0F, 5'h02, 32'd0};
    tbl[5] = '{mk(5'h05, 5'd0, 5'h0C, 0, 0),     1'b1, 1'b1, 5'h00, 5'h0C, 5'h00, 32'd0};
    tbl[6] = '{mk(5'h10, 5'd0, 5'h00, 0, 6'h10), 1'b1, 1'b0, 5'h00, 5'h00, 5'h00, 32'd0};
    tbl[7] = '{mk(5'h10, 5'd0, 5'h00, 0, 6'h01), 1'b1, 1'b1, 5'h00, 5'h00, 5'h00, 32'd0};
    tbl[8] = '{mk(5'h10, 5'd2, 5'h00, 0, 6'h10), 1'b1, 1'b1, 5'h00, 5'h00, 5'h02, 32'd0};
    tbl[9] = '{32'h8C22_7800,                    1'b0, 1'b0, 5'h00, 5'h0F, 5'h02, 32'd0};

    rst = 1'b1;
    i_exec_stall = 0; i_mem_stall = 0; i_fetch_stall = 0;
    i_instr = 0; i_cop0_alu_result_p2 = 0; i_irq = 0;
    i_exc_req = 0; i_exc_code = 0; i_exc_pc = 0;
    tick();
    tick();
    check("rst_redirect", 32'(o_redirect), 0);
    check("rst_pending", 32'(o_irq_pending), 0);
    check("rst_dec_err", 32'(o_decode_error), 0);
    check("rst_op_p1", 32'(o_cop0_op_p1), 0);
    check("rst_reg_val", o_cop0_reg_val_p1, 0);
    rst = 1'b0;
    tick();

    // Decode table
    for (int i = 0; i < 10; i++) begin
      i_instr = tbl[i].instr;
      tick();
      check($sformatf("dec%0d_op", i), 32'(o_cop0_op_p1), 32'(tbl[i].op));
      check($sformatf("dec%0d_err", i), 32'(o_decode_error), 32'(tbl[i].err));
      check($sformatf("dec%0d_cop", i), 32'(o_cop0_cop_p1), 32'(tbl[i].cop));
      check($sformatf("dec%0d_rd", i), 32'(o_cop0_reg_no_p1), 32'(tbl[i].rd));
      check($sformatf("dec%0d_rt", i), 32'(o_cop0_rt_no_p1), 32'(tbl[i].rt));
      check($sformatf("dec%0d_val", i), o_cop0_reg_val_p1, tbl[i].val);
    end
    i_instr = 0;
    repeat (4) tick();

    // IVT write/read, low bits read zero
    mtc0(5'h0A, 32'h1234_5678);
    expect_reg("ivt_read", 5'h0A, 32'h1234_5400);
    expect_reg("psr_unchanged", 5'h0B, 32'd0);
    expect_reg("epc_unchanged", 5'h0E, 32'd0);

    // Interrupt entry
    mtc0(5'h0C, 32'h0000_0101);
    i_exc_pc = 32'h100;
    i_irq = 4'b0001;
    tick();
    check("irq_sync1_pending", 32'(o_irq_pending), 0);
    tick();
    check("irq_sync2_pending", 32'(o_irq_pending), 1);
    tick();
    check("irq_redirect", 32'(o_redirect), 1);
    check("irq_redirect_pc", o_redirect_pc, 32'h1234_5400);
    check("irq_pending_in_entry", 32'(o_irq_pending), 0);
    tick();
    check("irq_redirect_end", 32'(o_redirect), 0);
    check("irq_pending_ie0", 32'(o_irq_pending), 0);
    i_irq = 0;
    repeat (3) tick();
    expect_reg("irq_epc", 5'h0E, 32'h100);
    expect_reg("irq_psr", 5'h0B, 32'd1);
    expect_reg("irq_sr", 5'h0C, 32'h100);
    expect_reg("irq_cause", 5'h0D, 32'd0);

    // RFE then masked interrupt
    rfe();
    expect_reg("rfe_sr", 5'h0C, 32'h101);
    expect_reg("rfe_psr", 5'h0B, 32'd0);
    mtc0(5'h0C, 32'h0000_0001);
    i_irq = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("masked_pending%0d", i), 32'(o_irq_pending), 0);
    end
    expect_reg("masked_cause", 5'h0D, 32'd0);
    i_irq = 0;
    repeat (3) tick();

    // Stalled exception concurrent with pending IRQ: exception wins
    mtc0(5'h0A, 32'h8000_0000);
    mtc0(5'h0C, 32'h0000_0101);
    i_exec_stall = 1; i_irq = 4'b0001;
    i_exc_req = 1; i_exc_code = 4'd3; i_exc_pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin i_exec_stall = 0; i_mem_stall = 1; end
      tick();
      check($sformatf("stall_no_redirect%0d", i), 32'(o_redirect), 0);
    end
    check("stall_pending", 32'(o_irq_pending), 1);
    i_mem_stall = 0;
    tick();
    check("exc_redirect", 32'(o_redirect), 1);
    check("exc_redirect_pc", o_redirect_pc, 32'h8000_0030);
    i_exc_req = 0;
    tick();
    check("exc_redirect_single", 32'(o_redirect), 0);
    i_irq = 0;
    repeat (3) tick();
    expect_reg("exc_cause", 5'h0D, 32'h0000_000C);
    expect_reg("exc_epc", 5'h0E, 32'h200);
    expect_reg("exc_psr", 5'h0B, 32'd1);
    expect_reg("exc_sr", 5'h0C, 32'h100);

    // Reset during ENTRY
    i_exc_req = 1; i_exc_code = 4'd5; i_exc_pc = 32'h300;
    tick();
    check("pre_rst_redirect", 32'(o_redirect), 1);
    check("pre_rst_pc", o_redirect_pc, 32'h8000_0050);
    i_exc_req = 0;
    rst = 1'b1;
    #1;
    check("rst_entry_redirect", 32'(o_redirect), 0);
    check("rst_entry_pc", o_redirect_pc, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_redirect%0d", i), 32'(o_redirect), 0);
    end
    expect_reg("post_rst_ivt", 5'h0A, 0);
    expect_reg("post_rst_epc", 5'h0E, 0);
    expect_reg("post_rst_sr", 5'h0C, 0);
    expect_reg("post_rst_psr", 5'h0B, 0);
    expect_reg("post_rst_cause", 5'h0D, 0);

    // Randomised operations against the register model
    m_ivt = 0; m_psr = 0; m_sr = 0; m_epc = 0; m_cause = 0;
    for (int it = 0; it < 80; it++) begin
      repeat ($urandom_range(0, 2)) begin
        i_exec_stall  = 1'($urandom_range(0, 1));
        i_mem_stall   = 1'($urandom_range(0, 1));
        i_fetch_stall = ~(i_exec_stall | i_mem_stall);
        tick();
        i_exec_stall = 0; i_mem_stall = 0; i_fetch_stall = 0;
      end
      case ($urandom_range(0, 3))
        0: begin
          rd = pick_reg();
          d  = $urandom;
          mtc0(rd, d);
          case (rd)
            5'h0A: m_ivt = d & 32'hFFFF_FC00;
            5'h0B: m_psr = d & 32'h1;
            5'h0C: m_sr  = d & 32'h0000_0F01;
            5'h0E: m_epc = d;
            default: ;
          endcase
        end
        1: begin
          rd = pick_reg();
          mfc0(rd, v);
          check($sformatf("rnd%0d_mf_r%0h", it, rd), v, model_read(rd));
        end
        2: begin
          code = 4'($urandom_range(1, 15));
          pc   = $urandom;
          i_exc_req = 1; i_exc_code = code; i_exc_pc = pc;
          tick();
          i_exc_req = 0;
          check($sformatf("rnd%0d_redirect", it), 32'(o_redirect), 1);
          check($sformatf("rnd%0d_vec", it), o_redirect_pc, m_ivt + (32'(code) * 16));
          m_epc = pc;
          m_psr = m_sr & 32'h1;
          m_sr  = m_sr & ~32'h1;
          m_cause = 32'(code) * 4;
          tick();
          check($sformatf("rnd%0d_redirect_end", it), 32'(o_redirect), 0);
        end
        default: begin
          rfe();
          m_sr  = (m_sr & ~32'h1) | m_psr;
          m_psr = 0;
        end
      endcase
      check($sformatf("rnd%0d_no_pending", it), 32'(o_irq_pending), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/coproc0_irq.md
Name: coproc0_irq

Overview:
Parametrised successor to the system coprocessor. It keeps the MFC0/MTC0/RFE pipeline of the existing coprocessor and adds these:
- NIRQ external interrupt lines with synchronisers, mask and pending bits.
- A CAUSE register.
- An exception-entry state machine that saves EPC and IE and issues a vectored PC redirect to the control unit.

It sits beside the integer pipeline: decode reads at p1, ALU value is captured at p2, and registers are written at p3/writeback.

Parameters:
NIRQ, 4, number of external interrupt lines (1..8)
VEC_SHIFT, 4, log2 of vector slot size in bytes; vector = IVT + (code << VEC_SHIFT)
SYNC_STAGES, 2, synchroniser flops per interrupt line (2..3)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
i_exec_stall  in  1  CU stall
i_mem_stall  in  1  CU stall
i_fetch_stall  in  1  CU stall
i_instr  in  32  fetched instruction
i_cop0_alu_result_p2  in  32  MTC0 data from execute
i_irq  in  NIRQ  asynchronous level interrupt lines, active-high
i_exc_req  in  1  synchronous exception request from CU (one cycle)
i_exc_code  in  4  exception code, 1..15 (0 reserved for interrupts)
i_exc_pc  in  32  PC to save in EPC
o_decode_error  out  1  malformed COP0 instruction at p1
o_cop0_op_p1  out  1  COP0 instruction at p1
o_cop0_cop_p1  out  5  MF/MT subop, else 0
o_cop0_reg_no_p1  out  5  rd field
o_cop0_rt_no_p1  out  5  rt field
o_cop0_reg_val_p1  out  32  MFC0 read value
o_irq_pending  out  1  interrupt will be taken at next non-stalled cycle
o_redirect  out  1  one-cycle pulse: flush and jump
o_redirect_pc  out  32  vector address, valid with o_redirect

Behaviour:
- core_stall = OR of the three stall inputs. All pipeline registers advance only when !core_stall.
- p1 decode, o_decode_error rules and p1→p2→p3 pipelining follow the existing COP0 contract: MF/MT require rsvd/func zero; CO requires func=RFE with rt/rd/rsvd zero; any other subop is an error.
- Register map (unlisted numbers read 0, writes ignored):
  - 0x0A IVT: bits[31:10] RW, [9:0] read 0.
  - 0x0B PSR: bit0 saved IE.
  - 0x0C SR: bit0 IE; bits[8+NIRQ-1:8] IM mask.
  - 0x0D CAUSE: read-only; bits[8+NIRQ-1:8] IP (live pending), bits[5:2] last code.
  - 0x0E EPC.
  - 0x0F PRID = `CPU_PROCID_CODE.
- Interrupt path:
  - Each i_irq bit passes SYNC_STAGES flops; IP = synced & IM.
  - o_irq_pending = SR.IE & |IP & (state==IDLE).
  - Combinational with respect to registered state; no extra latency beyond the synchroniser.
- FSM states: IDLE, ENTRY.
  - IDLE→ENTRY when !core_stall and (i_exc_req or o_irq_pending).
    - Exception has priority over interrupt.
    - For an interrupt, code = 0.
  - On that edge:
    - EPC ← i_exc_pc.
    - PSR.IE ← SR.IE.
    - SR.IE ← 0.
    - CAUSE.code ← code.
    - Latch vector = {IVT[31:10],10'b0} + (code << VEC_SHIFT), 32-bit wrap.
  - ENTRY: o_redirect=1 with o_redirect_pc = latched vector for exactly one cycle, then →IDLE regardless of stall.
  - i_exc_req arriving while in ENTRY is ignored; the CU must not issue it, because it flushes on redirect.
- Writeback (p3, !core_stall):
  - MT writes the register selected by rd.
  - RFE: SR.IE ← PSR.IE, PSR.IE ← 0.
  - Same-edge entry and p3 MT/RFE: entry updates of EPC/PSR/SR.IE/CAUSE win; MT to IVT or SR.IM still takes effect.
- A p3 MT to SR that sets IE takes effect the cycle after writeback; o_irq_pending may assert then.
- Reset (async, rst=1):
  - instr ← NOP; all p2/p3 registers 0.
  - IVT, PSR, SR (IE and IM), EPC, CAUSE.code 0; synchronisers 0.
  - state IDLE.
  - All outputs 0 except o_cop0_reg_val_p1 follows the decode of NOP (0).
- Reset asserted mid-ENTRY: o_redirect drops immediately; no redirect is issued after release.

Optional Feature:
COP0_CYCLE_COUNT_EN:
- Defined: register 0x09 COUNT, 32-bit, increments every clk including stalls, wraps 0xFFFF_FFFF→0.
  - MT to 0x09 loads the value; the increment resumes from the loaded value next cycle.
  - MF returns the current value.
- Undefined: 0x09 reads 0, writes are ignored, no counter flops.

Test Plan:
- MTC0 IVT=0x1234_5678, then MFC0 IVT -> reads 0x1234_5400; PSR/EPC unchanged.
- SR=0x0000_0101 (IE=1, IM0=1); raise i_irq[0] -> o_irq_pending after SYNC_STAGES+0 cycles; entry with i_exc_pc=0x100 -> EPC=0x100, PSR=1, SR.IE=0, CAUSE[5:2]=0, o_redirect pulse with PC=IVT.
- IVT=0x8000_0000, i_exc_req code=3 same cycle as pending IRQ -> exception wins, o_redirect_pc=0x8000_0030, CAUSE.code=3.
- Hold core_stall=1 with i_exc_req high -> no entry; release -> entry on the first non-stalled edge, single o_redirect pulse.
- RFE after entry -> SR.IE=1, PSR=0; IRQ masked (IM0=0) -> o_irq_pending stays 0 though CAUSE.IP0 reads 0.
- COP0 subop 0x05 -> o_decode_error=1; CO with func≠RFE -> error; rst pulse during ENTRY -> o_redirect=0 immediately, all registers zero.
